// File: rtl/otg_hpi_pkg.sv
// Shared types and constants for the OTG HPI bus controller.
// The controller turns each Avalon access into one timed CY7C67200 HPI cycle.
package otg_hpi_pkg;

  localparam int unsigned PHASE_W = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 2;

  localparam logic [ADDR_W-1:0] HPI_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] HPI_MAILBOX = 2'd1;
  localparam logic [ADDR_W-1:0] HPI_ADDRESS = 2'd2;
  localparam logic [ADDR_W-1:0] HPI_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_TURN   = 3'd4,
    ST_DONE   = 3'd5
  } hpi_state_e;

  // Request captured at acceptance and held for the whole HPI cycle.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } hpi_req_t;

  // Phase length in cycles -> counter load value (terminal count at zero).
  function automatic logic [PHASE_W-1:0] phase_load(int unsigned cyc);
    return PHASE_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/otg_hpi_bus_ctrl_if.sv
// Avalon-MM slave side plus HPI pin side of the OTG HPI bus controller.
// slave is the controller's view, master is the view of whatever drives it.
interface otg_hpi_bus_ctrl_if;
  import otg_hpi_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;
  logic              busy;

  logic [ADDR_W-1:0] otg_hpi_addr;
  logic              otg_hpi_cs_n;
  logic              otg_hpi_r_n;
  logic              otg_hpi_w_n;
  logic [DATA_W-1:0] otg_hpi_data_out;
  logic              otg_hpi_data_oe;
  logic [DATA_W-1:0] otg_hpi_data_in;

  modport slave (
    input  address, chipselect, read, write, writedata, otg_hpi_data_in,
    output readdata, waitrequest, busy,
    output otg_hpi_addr, otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n,
    output otg_hpi_data_out, otg_hpi_data_oe
  );

  modport master (
    output address, chipselect, read, write, writedata, otg_hpi_data_in,
    input  readdata, waitrequest, busy,
    input  otg_hpi_addr, otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n,
    input  otg_hpi_data_out, otg_hpi_data_oe
  );

endinterface

// File: rtl/otg_hpi_phase_timer.sv
// Loadable down-counter timing one HPI phase; tc_o is high in the last
// cycle of the phase, so a load of N-1 yields a phase N cycles long.
module otg_hpi_phase_timer
  import otg_hpi_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [PHASE_W-1:0] load_val_i,
  output logic               tc_o
);

  logic [PHASE_W-1:0] count_q, count_d;
  logic               tc_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - PHASE_W'(1);
    end
  end

  // Terminal count is registered alongside the count it decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      tc_q    <= (count_d == '0);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/otg_hpi_bus_ctrl.sv
// Avalon-MM slave to CY7C67200 HPI bus master: one timed HPI cycle per access,
// with waitrequest stalling the master until the cycle's DONE beat.
module otg_hpi_bus_ctrl
  import otg_hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned TURN_CYC   = 2
) (
  input  logic               clk,
  input  logic               reset,
  otg_hpi_bus_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_SETUP  = 3'(ST_SETUP);
  localparam logic [2:0] S_STROBE = 3'(ST_STROBE);
  localparam logic [2:0] S_HOLD   = 3'(ST_HOLD);
  localparam logic [2:0] S_TURN   = 3'(ST_TURN);
  localparam logic [2:0] S_DONE   = 3'(ST_DONE);

  logic [2:0]         state_q, state_d;
  hpi_req_t           req_q, req_d;
  logic               req_c;
  logic               wait_c;
  logic               tmr_load;
  logic [PHASE_W-1:0] tmr_val;
  logic               tmr_tc;

  logic               cs_n_q, cs_n_d;
  logic               r_n_q, r_n_d;
  logic               w_n_q, w_n_d;
  logic               oe_q, oe_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               bus_active_d;

  assign req_c = bus.chipselect & (bus.read | bus.write);

  otg_hpi_phase_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // Next state, phase timer reload and next values of the registered pins.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    rdata_d  = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          state_d     = S_SETUP;
          req_d.write = bus.write;
          req_d.addr  = bus.address;
          req_d.wdata = bus.writedata;
        end
      end
      S_SETUP:  if (tmr_tc) state_d = S_STROBE;
      S_STROBE: begin
        if (tmr_tc) begin
          state_d = S_HOLD;
          if (!req_q.write) rdata_d = bus.otg_hpi_data_in;
        end
      end
      S_HOLD:   if (tmr_tc) state_d = S_TURN;
      S_TURN:   if (tmr_tc) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    tmr_load = (state_d != state_q);
    case (state_d)
      S_SETUP:  tmr_val = phase_load(SETUP_CYC);
      S_STROBE: tmr_val = phase_load(STROBE_CYC);
      S_HOLD:   tmr_val = phase_load(HOLD_CYC);
      S_TURN:   tmr_val = phase_load(TURN_CYC);
      default:  tmr_val = '0;
    endcase

    // Pins reflect the state being entered so they change on the same edge.
    bus_active_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    cs_n_d = !bus_active_d;
    r_n_d  = !((state_d == S_STROBE) && !req_d.write);
    w_n_d  = !((state_d == S_STROBE) &&  req_d.write);
    oe_d   = bus_active_d && req_d.write;
    busy_d = (state_d != S_IDLE);
    addr_d = req_d.addr;
    dout_d = req_d.wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cs_n_q  <= 1'b1;
      r_n_q   <= 1'b1;
      w_n_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cs_n_q  <= cs_n_d;
      r_n_q   <= r_n_d;
      w_n_q   <= w_n_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall: passes the request through in IDLE, released only in DONE.
  always_comb begin
    wait_c = 1'b1;
    case (state_q)
      S_IDLE:  wait_c = req_c;
      S_DONE:  wait_c = 1'b0;
      default: wait_c = 1'b1;
    endcase
  end

  assign bus.waitrequest      = wait_c;
  assign bus.busy             = busy_q;
  assign bus.readdata         = rdata_q;
  assign bus.otg_hpi_addr     = addr_q;
  assign bus.otg_hpi_cs_n     = cs_n_q;
  assign bus.otg_hpi_r_n      = r_n_q;
  assign bus.otg_hpi_w_n      = w_n_q;
  assign bus.otg_hpi_data_out = dout_q;
  assign bus.otg_hpi_data_oe  = oe_q;

endmodule

// File: tb/tb_otg_hpi_bus_ctrl.sv
// Bench for otg_hpi_bus_ctrl: a default-timing instance and an all-ones
// instance, each checked every cycle against a cycle-offset timing model.
module tb_otg_hpi_bus_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  otg_hpi_bus_ctrl_if hif0 ();
  otg_hpi_bus_ctrl_if hif1 ();

  otg_hpi_bus_ctrl dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (hif0)
  );

  otg_hpi_bus_ctrl #(
    .SETUP_CYC  (1),
    .STROBE_CYC (1),
    .HOLD_CYC   (1),
    .TURN_CYC   (1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (hif1)
  );

  int ps[2]  = '{2, 1};
  int pst[2] = '{4, 1};
  int ph[2]  = '{2, 1};
  int pt[2]  = '{2, 1};

  typedef struct {
    logic        cs, rd, wr;
    logic [1:0]  a;
    logic [15:0] wd, din, rdata;
    logic        wt, busy;
    logic [1:0]  haddr;
    logic        cs_n, r_n, w_n, oe;
    logic [15:0] dout;
  } snap_t;

  function automatic snap_t get_snap(int id);
    snap_t s;
    if (id == 0) begin
      s.cs = hif0.chipselect; s.rd = hif0.read; s.wr = hif0.write;
      s.a = hif0.address; s.wd = hif0.writedata; s.din = hif0.otg_hpi_data_in;
      s.rdata = hif0.readdata; s.wt = hif0.waitrequest; s.busy = hif0.busy;
      s.haddr = hif0.otg_hpi_addr; s.cs_n = hif0.otg_hpi_cs_n;
      s.r_n = hif0.otg_hpi_r_n; s.w_n = hif0.otg_hpi_w_n;
      s.oe = hif0.otg_hpi_data_oe; s.dout = hif0.otg_hpi_data_out;
    end else begin
      s.cs = hif1.chipselect; s.rd = hif1.read; s.wr = hif1.write;
      s.a = hif1.address; s.wd = hif1.writedata; s.din = hif1.otg_hpi_data_in;
      s.rdata = hif1.readdata; s.wt = hif1.waitrequest; s.busy = hif1.busy;
      s.haddr = hif1.otg_hpi_addr; s.cs_n = hif1.otg_hpi_cs_n;
      s.r_n = hif1.otg_hpi_r_n; s.w_n = hif1.otg_hpi_w_n;
      s.oe = hif1.otg_hpi_data_oe; s.dout = hif1.otg_hpi_data_out;
    end
    return s;
  endfunction

  task automatic chk(string name, int id, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, id, cyc, act, exp);
    end
  endtask

  task automatic drive(int id, logic cs, logic rd, logic wr, logic [1:0] a,
                       logic [15:0] wd, logic [15:0] din);
    if (id == 0) begin
      hif0.chipselect = cs; hif0.read = rd; hif0.write = wr;
      hif0.address = a; hif0.writedata = wd; hif0.otg_hpi_data_in = din;
    end else begin
      hif1.chipselect = cs; hif1.read = rd; hif1.write = wr;
      hif1.address = a; hif1.writedata = wd; hif1.otg_hpi_data_in = din;
    end
  endtask

  // Timing model: a transaction accepted at cycle s occupies offsets 1..L,
  // with cs low for the first S+St+H offsets and the strobe in S+1..S+St.
  int          m_act[2]   = '{0, 0};
  int          m_start[2] = '{0, 0};
  logic        m_wr[2]    = '{1'b0, 1'b0};
  logic [1:0]  m_addr[2]  = '{2'd0, 2'd0};
  logic [15:0] m_wd[2]    = '{16'd0, 16'd0};
  logic [15:0] m_rd[2]    = '{16'd0, 16'd0};

  task automatic model_check(int id);
    snap_t s;
    int    k, L, S, St, H;
    bit    act, req, cs_lo, stb;
    logic  e_wait, e_oe, e_r_n, e_w_n, e_busy;
    s  = get_snap(id);
    S  = ps[id]; St = pst[id]; H = ph[id];
    L  = 1 + S + St + H + pt[id];
    req = s.cs & (s.rd | s.wr);
    if (reset) begin
      m_act[id] = 0; m_wr[id] = 1'b0; m_addr[id] = '0; m_wd[id] = '0; m_rd[id] = '0;
    end
    act = (m_act[id] != 0);
    k   = cyc - m_start[id];
    if (act && k > L) act = 0;
    m_act[id] = act ? 1 : 0;
    if (!act) begin
      cs_lo = 0; stb = 0; e_busy = 1'b0; e_wait = req;
    end else begin
      cs_lo  = (k >= 1) && (k <= S + St + H);
      stb    = (k >= S + 1) && (k <= S + St);
      e_busy = 1'b1;
      e_wait = (k != L);
    end
    e_oe  = cs_lo && m_wr[id];
    e_r_n = !(stb && !m_wr[id]);
    e_w_n = !(stb &&  m_wr[id]);
    chk("waitrequest", id, 16'(s.wt), 16'(e_wait));
    chk("busy", id, 16'(s.busy), 16'(e_busy));
    chk("cs_n", id, 16'(s.cs_n), 16'(!cs_lo));
    chk("r_n", id, 16'(s.r_n), 16'(e_r_n));
    chk("w_n", id, 16'(s.w_n), 16'(e_w_n));
    chk("data_oe", id, 16'(s.oe), 16'(e_oe));
    chk("hpi_addr", id, 16'(s.haddr), 16'(m_addr[id]));
    chk("readdata", id, s.rdata, m_rd[id]);
    if (e_oe) chk("data_out", id, s.dout, m_wd[id]);
    if (!reset) begin
      if (act && !m_wr[id] && k == S + St) m_rd[id] = s.din;
      if (!act && req) begin
        m_act[id] = 1; m_start[id] = cyc; m_wr[id] = s.wr;
        m_addr[id] = s.a; m_wd[id] = s.wd;
      end
    end
  endtask

  always @(negedge clk) begin
    model_check(0);
    model_check(1);
  end

  typedef struct {
    int done, cs_first, cs_last, w_first, w_cnt, r_first, r_cnt, oe_first, oe_last, oe_cnt;
    logic [1:0]  addr;
    logic [15:0] dout, rdata;
  } obs_t;

  // Issue one access now (called at posedge+1) and observe it until DONE.
  task automatic run_tx(int id, logic rd, logic wr, logic [1:0] a, logic [15:0] wd,
                        logic [15:0] din, bit keep, output obs_t o, output int start);
    snap_t s;
    int    off;
    o = '{done: -1, cs_first: -1, cs_last: -1, w_first: -1, w_cnt: 0, r_first: -1,
          r_cnt: 0, oe_first: -1, oe_last: -1, oe_cnt: 0, addr: 2'd0, dout: 16'd0, rdata: 16'd0};
    drive(id, 1'b1, rd, wr, a, wd, din);
    start = cyc;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      s   = get_snap(id);
      off = cyc - start;
      if (!s.cs_n) begin
        if (o.cs_first < 0) o.cs_first = off;
        o.cs_last = off; o.addr = s.haddr;
      end
      if (!s.w_n) begin if (o.w_first < 0) o.w_first = off; o.w_cnt++; end
      if (!s.r_n) begin if (o.r_first < 0) o.r_first = off; o.r_cnt++; end
      if (s.oe) begin
        if (o.oe_first < 0) o.oe_first = off;
        o.oe_last = off; o.oe_cnt++; o.dout = s.dout;
      end
      if (!s.wt) begin o.done = off; o.rdata = s.rdata; break; end
    end
    if (o.done < 0) begin
      n_checks++; n_fail++;
      $display("FAIL tx_timeout dut%0d start=%0d no DONE within 64 cycles", id, start);
    end
    @(posedge clk); #1;
    if (!keep) drive(id, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
  endtask

  initial begin
    obs_t o, o2;
    int   st, st2;
    drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_cs_n", 0, 16'(hif0.otg_hpi_cs_n), 16'd1);
    chk("rst_busy", 0, 16'(hif0.busy), 16'd0);
    chk("rst_readdata", 0, hif0.readdata, 16'd0);
    chk("rst_wait", 0, 16'(hif0.waitrequest), 16'd0);

    // Plain write to ADDRESS register.
    run_tx(0, 1'b0, 1'b1, 2'd2, 16'h1234, 16'h0, 1'b0, o, st);
    chk("wr_done", 0, 16'(o.done), 16'd11);
    chk("wr_cs_first", 0, 16'(o.cs_first), 16'd1);
    chk("wr_cs_last", 0, 16'(o.cs_last), 16'd8);
    chk("wr_w_first", 0, 16'(o.w_first), 16'd3);
    chk("wr_w_cnt", 0, 16'(o.w_cnt), 16'd4);
    chk("wr_r_cnt", 0, 16'(o.r_cnt), 16'd0);
    chk("wr_oe_first", 0, 16'(o.oe_first), 16'd1);
    chk("wr_oe_last", 0, 16'(o.oe_last), 16'd8);
    chk("wr_dout", 0, o.dout, 16'h1234);
    chk("wr_addr", 0, 16'(o.addr), 16'd2);
    repeat (2) @(posedge clk); #1;

    // Plain read of DATA register.
    run_tx(0, 1'b1, 1'b0, 2'd0, 16'h0, 16'hBEEF, 1'b0, o, st);
    chk("rd_done", 0, 16'(o.done), 16'd11);
    chk("rd_r_first", 0, 16'(o.r_first), 16'd3);
    chk("rd_r_cnt", 0, 16'(o.r_cnt), 16'd4);
    chk("rd_oe_cnt", 0, 16'(o.oe_cnt), 16'd0);
    chk("rd_data", 0, o.rdata, 16'hBEEF);
    repeat (3) @(posedge clk); #1;

    // Back-to-back write then read with the request held throughout.
    run_tx(0, 1'b0, 1'b1, 2'd3, 16'h5A5A, 16'h0, 1'b1, o, st);
    run_tx(0, 1'b1, 1'b0, 2'd1, 16'h0, 16'h0F0F, 1'b0, o2, st2);
    chk("b2b_first_done", 0, 16'(o.done), 16'd11);
    chk("b2b_second_start", 0, 16'(st2 - st), 16'd12);
    chk("b2b_second_done", 0, 16'(st2 + o2.done - st), 16'd23);
    chk("b2b_second_cs", 0, 16'(st2 + o2.cs_first - st), 16'd13);
    chk("b2b_rdata", 0, o2.rdata, 16'h0F0F);
    repeat (2) @(posedge clk); #1;

    // read and write together: treated as a write; readdata untouched.
    run_tx(0, 1'b1, 1'b1, 2'd1, 16'hA5C3, 16'h7777, 1'b0, o, st);
    chk("rw_w_cnt", 0, 16'(o.w_cnt), 16'd4);
    chk("rw_r_cnt", 0, 16'(o.r_cnt), 16'd0);
    chk("rw_addr", 0, 16'(o.addr), 16'd1);
    chk("rw_rdata_hold", 0, o.rdata, 16'h0F0F);
    repeat (2) @(posedge clk); #1;

    // Reset in cycle 4 of a write, then a normal read.
    drive(0, 1'b1, 1'b0, 1'b1, 2'd0, 16'hCAFE, 16'h0);
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_w_n", 0, 16'(hif0.otg_hpi_w_n), 16'd0);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
    #1;
    chk("mid_rst_cs_n", 0, 16'(hif0.otg_hpi_cs_n), 16'd1);
    chk("mid_rst_w_n", 0, 16'(hif0.otg_hpi_w_n), 16'd1);
    chk("mid_rst_oe", 0, 16'(hif0.otg_hpi_data_oe), 16'd0);
    chk("mid_rst_busy", 0, 16'(hif0.busy), 16'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    run_tx(0, 1'b1, 1'b0, 2'd2, 16'h0, 16'h1357, 1'b0, o, st);
    chk("post_rst_done", 0, 16'(o.done), 16'd11);
    chk("post_rst_rdata", 0, o.rdata, 16'h1357);
    repeat (2) @(posedge clk); #1;

    // All phases one cycle long.
    run_tx(1, 1'b0, 1'b1, 2'd3, 16'h00FF, 16'h0, 1'b0, o, st);
    chk("p1_done", 1, 16'(o.done), 16'd5);
    chk("p1_w_cnt", 1, 16'(o.w_cnt), 16'd1);
    chk("p1_w_first", 1, 16'(o.w_first), 16'd2);
    run_tx(1, 1'b1, 1'b0, 2'd0, 16'h0, 16'h4242, 1'b0, o, st);
    chk("p1_rd_done", 1, 16'(o.done), 16'd5);
    chk("p1_rdata", 1, o.rdata, 16'h4242);
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
